pwm_set_gen: RTL



---
 rtl/pwm_set_gen_pkg.sv | 25 ++
 rtl/pwm_set_gen_period_timer.sv | 54 +++++
 rtl/pwm_set_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/pwm_set_gen_pkg.sv
// Shared definitions for the fixed-frequency PWM set generator.
package pwm_set_gen_pkg;

    localparam int COUNTER_WIDTH = 21;
    localparam int SKIP_WIDTH    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [SKIP_WIDTH-1:0] sat_inc(input logic [SKIP_WIDTH-1:0] value);
        logic [SKIP_WIDTH-1:0] result;
        if (value == {SKIP_WIDTH{1'b1}}) begin
            result = value;
        end else begin
            result = value + SKIP_WIDTH'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_set_gen_period_timer.sv
// Switching-period counter: counts 0..P-1 while enabled and flags the boundary cycle.
// The period length is captured in the cycle where the count restarts at zero.
module pwm_set_gen_period_timer
    import pwm_set_gen_pkg::*;
#(
    parameter int counter_width = COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [counter_width-1:0] period,
    output logic                     bnd
);

    localparam logic [counter_width-1:0] CNT_ZERO   = {counter_width{1'b0}};
    localparam logic [counter_width-1:0] CNT_ONE    = counter_width'(1);
    localparam logic [counter_width-1:0] MIN_PERIOD = counter_width'(2);

    logic [counter_width-1:0] pcnt_r;
    logic [counter_width-1:0] plen_r;
    logic [counter_width-1:0] plen_in_s;
    logic                     wrap_s;

    // Clamp the requested period so a period always spans at least two cycles.
    always_comb begin
        plen_in_s = period;
        if (period < MIN_PERIOD) begin
            plen_in_s = MIN_PERIOD;
        end else begin
            plen_in_s = period;
        end
    end

    assign wrap_s = (pcnt_r >= (plen_r - CNT_ONE));
    assign bnd    = (pcnt_r == CNT_ZERO) && enable;

    // Period counter; a new length only applies from the period that starts next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r <= CNT_ZERO;
            plen_r <= MIN_PERIOD;
        end else if (!enable) begin
            pcnt_r <= CNT_ZERO;
        end else if (pcnt_r == CNT_ZERO) begin
            plen_r <= plen_in_s;
            pcnt_r <= CNT_ONE;
        end else if (wrap_s) begin
            pcnt_r <= CNT_ZERO;
        end else begin
            pcnt_r <= pcnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/pwm_set_gen.sv
// Fixed-frequency PWM initiator: pulses set at each period boundary, holds pwm_out until
// the on-time timer (or the ton_max backstop) ends the pulse, then enforces a minimum off-time.
module pwm_set_gen
    import pwm_set_gen_pkg::*;
#(
    parameter int counter_width = COUNTER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [counter_width-1:0] period,
    input  logic [counter_width-1:0] toff_min,
    input  logic [counter_width-1:0] ton_max,
    input  logic                     reset_pwm,
    output logic                     set,
    output logic                     pwm_out,
    output logic                     ton_max_hit,
    output logic [SKIP_WIDTH-1:0]    skip_cnt
);

    localparam logic [counter_width-1:0] CNT_ZERO = {counter_width{1'b0}};
    localparam logic [counter_width-1:0] CNT_ONE  = counter_width'(1);

    state_t                   state_r;
    logic [counter_width-1:0] ton_cnt_r;
    logic [counter_width-1:0] toff_cnt_r;
    logic                     set_r;
    logic                     pwm_r;
    logic                     hit_r;
    logic [SKIP_WIDTH-1:0]    skip_r;
    logic                     bnd_s;

    pwm_set_gen_period_timer #(
        .counter_width(counter_width)
    ) u_period_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(enable),
        .period(period),
        .bnd   (bnd_s)
    );

    // Control FSM with registered outputs; dropping enable returns everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ton_cnt_r  <= CNT_ZERO;
            toff_cnt_r <= CNT_ZERO;
            set_r      <= 1'b0;
            pwm_r      <= 1'b0;
            hit_r      <= 1'b0;
            skip_r     <= {SKIP_WIDTH{1'b0}};
        end else if (!enable) begin
            state_r    <= ST_IDLE;
            ton_cnt_r  <= CNT_ZERO;
            toff_cnt_r <= CNT_ZERO;
            set_r      <= 1'b0;
            pwm_r      <= 1'b0;
            hit_r      <= 1'b0;
            skip_r     <= {SKIP_WIDTH{1'b0}};
        end else begin
            set_r <= 1'b0;
            hit_r <= 1'b0;
            // A boundary that lands while a pulse or off-time is still running is lost.
            if (bnd_s && ((state_r == ST_ON) || (state_r == ST_OFF))) begin
                skip_r <= sat_inc(skip_r);
            end
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_WAIT;
                    pwm_r   <= 1'b0;
                end
                ST_WAIT: begin
                    if (bnd_s) begin
                        state_r   <= ST_ON;
                        set_r     <= 1'b1;
                        pwm_r     <= 1'b1;
                        ton_cnt_r <= CNT_ZERO;
                    end
                end
                ST_ON: begin
                    if (reset_pwm) begin
                        state_r    <= ST_OFF;
                        pwm_r      <= 1'b0;
                        toff_cnt_r <= CNT_ZERO;
                    end else if (ton_cnt_r >= ton_max) begin
                        state_r    <= ST_OFF;
                        pwm_r      <= 1'b0;
                        hit_r      <= 1'b1;
                        toff_cnt_r <= CNT_ZERO;
                    end else begin
                        ton_cnt_r <= ton_cnt_r + CNT_ONE;
                    end
                end
                ST_OFF: begin
                    if (toff_cnt_r >= toff_min) begin
                        state_r <= ST_WAIT;
                    end else begin
                        toff_cnt_r <= toff_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    pwm_r   <= 1'b0;
                end
            endcase
        end
    end

    assign set         = set_r;
    assign pwm_out     = pwm_r;
    assign ton_max_hit = hit_r;
    assign skip_cnt    = skip_r;

endmodule
